// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Groups the request/response handshake between the MEM pipeline stage and
//   the load/store unit, together with the data memory port the unit drives.
//   master : pipeline + memory side (drives requests, rsp_ready and Memout)
//   slave  : mem_access_unit side (drives req_ready, responses and memory port)
//   Signals:
//     req_valid/req_ready/req_op/req_addr/req_wdata   request channel
//     rsp_valid/rsp_ready/rsp_data/rsp_exc/rsp_badaddr response channel
//     MemAddr/Memdata/MemWrite/dmCon                   memory command
//     Memout                                           memory read word
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_exc;
  logic [31:0] rsp_badaddr;
  logic [31:0] MemAddr;
  logic [31:0] Memdata;
  logic        MemWrite;
  logic [1:0]  dmCon;
  logic [31:0] Memout;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, Memout,
    input  req_ready, rsp_valid, rsp_data, rsp_exc, rsp_badaddr,
           MemAddr, Memdata, MemWrite, dmCon
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, Memout,
    output req_ready, rsp_valid, rsp_data, rsp_exc, rsp_badaddr,
           MemAddr, Memdata, MemWrite, dmCon
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator between the MEM stage and the data memory. Takes one
//   request per handshake, checks alignment and range, performs the word/half/
//   byte access (optionally stretched by WAIT_CYCLES), extracts and extends
//   load data, and returns exactly one response per accepted request.
//   Ports:
//     Clk     in  clock, rising edge
//     reset   in  synchronous, active-high
//     io_bus  slave view of mem_access_unit_if (request, response, memory)
//   Parameters:
//     WAIT_CYCLES  extra memory cycles per access (0..15)
//     DM_BYTES     data memory size in bytes; addresses at or above fault
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned DM_BYTES    = 8192
) (
  input  logic                  Clk,
  input  logic                  reset,
  mem_access_unit_if.slave      io_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } StateT;

  localparam logic [2:0]  OpLw  = 3'd0;
  localparam logic [2:0]  OpLh  = 3'd1;
  localparam logic [2:0]  OpLhu = 3'd2;
  localparam logic [2:0]  OpLb  = 3'd3;
  localparam logic [2:0]  OpLbu = 3'd4;
  localparam logic [2:0]  OpSw  = 3'd5;
  localparam logic [2:0]  OpSh  = 3'd6;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam logic [31:0] DmLimit  = 32'(DM_BYTES);

  StateT       r_state;
  StateT       w_nextState;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_waitCnt;
  logic [31:0] r_rspData;
  logic        r_rspExc;
  logic [31:0] r_rspBadAddr;

  logic [1:0]  w_reqSize;
  logic [1:0]  w_size;
  logic        w_reqErr;
  logic        w_accept;
  logic        w_isStore;
  logic        w_lastCycle;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic        w_reqReady;
  logic        w_rspValid;
  logic        w_memWrite;
  logic [1:0]  w_dmCon;

  // Access size encoded the way dmCon wants it: 0 word, 1 half, 2 byte.
  function automatic logic [1:0] opSize(input logic [2:0] op);
    logic [1:0] size;
    size = 2'd2;
    if (op == OpLw || op == OpSw)
      size = 2'd0;
    else if (op == OpLh || op == OpLhu || op == OpSh)
      size = 2'd1;
    return size;
  endfunction

  // Error check is done on the incoming request so a faulting access can go
  // straight to RESP without ever touching memory.
  always_comb begin
    w_reqSize = opSize(io_bus.req_op);
    w_reqErr  = ((w_reqSize == 2'd0) && (io_bus.req_addr[1:0] != 2'b00)) ||
                ((w_reqSize == 2'd1) && io_bus.req_addr[0]) ||
                (io_bus.req_addr >= DmLimit);
  end

  assign w_accept    = (r_state == IDLE) && io_bus.req_valid;
  assign w_size      = opSize(r_op);
  assign w_isStore   = (r_op >= OpSw);
  assign w_lastCycle = (r_state == ACCESS) && (r_waitCnt == 4'd0);

  // Load extraction from the word Memout returns for the latched address.
  always_comb begin
    w_byte     = 8'(io_bus.Memout >> {r_addr[1:0], 3'b000});
    w_half     = r_addr[1] ? io_bus.Memout[31:16] : io_bus.Memout[15:0];
    w_loadData = io_bus.Memout;
    case (r_op)
      OpLh:    w_loadData = {{16{w_half[15]}}, w_half};
      OpLhu:   w_loadData = {16'h0000, w_half};
      OpLb:    w_loadData = {{24{w_byte[7]}}, w_byte};
      OpLbu:   w_loadData = {24'h000000, w_byte};
      default: w_loadData = io_bus.Memout;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Request latch, wait counter and response registers. The response is
  // fixed at accept time for faults and at the last access cycle otherwise,
  // so it stays stable for as long as the consumer stalls.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_op         <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_waitCnt    <= 4'd0;
      r_rspData    <= 32'd0;
      r_rspExc     <= 1'b0;
      r_rspBadAddr <= 32'd0;
    end else if (w_accept) begin
      r_op         <= io_bus.req_op;
      r_addr       <= io_bus.req_addr;
      r_wdata      <= io_bus.req_wdata;
      r_waitCnt    <= WaitInit;
      r_rspData    <= 32'd0;
      r_rspExc     <= w_reqErr;
      r_rspBadAddr <= w_reqErr ? io_bus.req_addr : 32'd0;
    end else if (r_state == ACCESS) begin
      if (r_waitCnt != 4'd0)
        r_waitCnt <= r_waitCnt - 4'd1;
      else
        r_rspData <= w_isStore ? 32'd0 : w_loadData;
    end
  end

  // Next state and handshake/memory strobes.
  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 1'b0;
    w_rspValid  = 1'b0;
    w_memWrite  = 1'b0;
    w_dmCon     = 2'd0;
    unique case (r_state)
      IDLE: begin
        w_reqReady = 1'b1;
        if (io_bus.req_valid)
          w_nextState = w_reqErr ? RESP : ACCESS;
      end
      ACCESS: begin
        w_dmCon = w_size;
        if (w_lastCycle) begin
          w_memWrite  = w_isStore;
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_rspValid = 1'b1;
        if (io_bus.rsp_ready)
          w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign io_bus.req_ready   = w_reqReady;
  assign io_bus.rsp_valid   = w_rspValid;
  assign io_bus.rsp_data    = w_rspValid ? r_rspData : 32'd0;
  assign io_bus.rsp_exc     = w_rspValid & r_rspExc;
  assign io_bus.rsp_badaddr = w_rspValid ? r_rspBadAddr : 32'd0;
  assign io_bus.MemAddr     = r_addr;
  assign io_bus.Memdata     = r_wdata;
  // Reset must suppress a write that would otherwise land on the same edge.
  assign io_bus.MemWrite    = w_memWrite & ~reset;
  assign io_bus.dmCon       = w_dmCon;

endmodule
